// File: rtl/redmule_mmio_pkg.sv
// redmule_mmio_pkg: register map, STATUS bit positions and response bundle
// shared by the MMIO responder and its console FIFO.
package redmule_mmio_pkg;

   localparam logic [11:0] MMIO_OFF_EXIT     = 12'h000;
   localparam logic [11:0] MMIO_OFF_PRINT    = 12'h004;
   localparam logic [11:0] MMIO_OFF_CYCLE_HI = 12'h008;
   localparam logic [11:0] MMIO_OFF_STATUS   = 12'h00C;

   localparam int unsigned STATUS_EXIT_BIT  = 0;
   localparam int unsigned STATUS_EMPTY_BIT = 1;
   localparam int unsigned STATUS_FULL_BIT  = 2;

   localparam logic [31:0] MMIO_ERR_RDATA = 32'hDEADBEEF;

   typedef struct packed {
      logic        rvalid;
      logic [31:0] rdata;
   } mmio_rsp_t;

endpackage

// File: rtl/redmule_mmio_fifo.sv
// redmule_mmio_fifo: synchronous FIFO for console bytes, power-of-two depth,
// with occupancy, free-entry, full and empty outputs.
module redmule_mmio_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o,
   output logic [AW:0]  free_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign free_o  = (AW+1)'(DEPTH) - cnt_q;
   assign data_o  = mem_q[rptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Simultaneous push and pop leave the occupancy unchanged.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/redmule_mmio_responder.sv
// redmule_mmio_responder: OBI-style MMIO window for exit code, console, cycles.
// Build option REDMULE_MMIO_PRINT_FIFO_EN buffers console bytes in a FIFO.
module redmule_mmio_responder
   import redmule_mmio_pkg::*;
#(
   parameter int unsigned PRINT_FIFO_DEPTH = 8,
   parameter logic [31:0] ERR_RDATA        = MMIO_ERR_RDATA
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_code_o,
   output logic        char_valid_o,
   output logic [7:0]  char_o,
   input  logic        char_ready_i
);

   localparam int unsigned AW = $clog2(PRINT_FIFO_DEPTH);

   logic [9:0]  woff;
   logic        sel_exit, sel_print, sel_hi, sel_status;
   logic        print_wr, acc, push;
   logic        fifo_full, fifo_empty;
   logic [AW:0] fifo_free;
   logic [31:0] status, rd_data;
   mmio_rsp_t   rsp_d, rsp_q;
   logic        exit_valid_d, exit_valid_q;
   logic [31:0] exit_code_d, exit_code_q;
   logic [31:0] hi_d, hi_q;
   logic [63:0] cnt_q;

   assign woff       = addr_i[11:2];
   assign sel_exit   = (woff == MMIO_OFF_EXIT[11:2]);
   assign sel_print  = (woff == MMIO_OFF_PRINT[11:2]);
   assign sel_hi     = (woff == MMIO_OFF_CYCLE_HI[11:2]);
   assign sel_status = (woff == MMIO_OFF_STATUS[11:2]);

   // Only byte-0 PRINT writes consume console space, so only they can stall.
   assign print_wr = we_i & be_i[0] & sel_print;
   assign gnt_o    = req_i & ~(print_wr & fifo_full);
   assign acc      = req_i & gnt_o;
   assign push     = acc & print_wr;

`ifdef REDMULE_MMIO_PRINT_FIFO_EN
   logic [7:0]  head;
   logic [AW:0] fifo_cnt;
   logic        pop;
   logic        unused_fifo;

   assign pop = char_valid_o & char_ready_i;

   redmule_mmio_fifo #(
      .DEPTH (PRINT_FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (wdata_i[7:0]),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt),
      .free_o  (fifo_free)
   );

   assign char_valid_o = ~fifo_empty;
   assign char_o       = fifo_empty ? 8'h00 : head;
   assign unused_fifo  = ^fifo_cnt;
`else
   logic unused_push;

   // No storage: the write itself is the character, held until the sink takes it.
   assign fifo_empty   = 1'b1;
   assign fifo_full    = ~char_ready_i;
   assign fifo_free    = '0;
   assign char_valid_o = req_i & print_wr;
   assign char_o       = wdata_i[7:0];
   assign unused_push  = push;
`endif

   always_comb begin
      status                   = '0;
      status[STATUS_EXIT_BIT]  = exit_valid_q;
      status[STATUS_EMPTY_BIT] = fifo_empty;
      status[STATUS_FULL_BIT]  = fifo_full;
   end

   always_comb begin
      rd_data = ERR_RDATA;
      unique case (1'b1)
         sel_exit:   rd_data = cnt_q[31:0];
         sel_print:  rd_data = 32'(fifo_free);
         sel_hi:     rd_data = hi_q;
         sel_status: rd_data = status;
         default:    rd_data = ERR_RDATA;
      endcase
   end

   // An EXIT read snapshots the upper counter half for a coherent 64-bit pair.
   always_comb begin
      exit_valid_d = exit_valid_q;
      exit_code_d  = exit_code_q;
      hi_d         = hi_q;
      rsp_d        = '0;
      rsp_d.rvalid = acc;
      if (acc && we_i && sel_exit) begin
         exit_valid_d = 1'b1;
         exit_code_d  = wdata_i;
      end
      if (acc && !we_i) begin
         rsp_d.rdata = rd_data;
         if (sel_exit) hi_d = cnt_q[63:32];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_q        <= '0;
         exit_valid_q <= 1'b0;
         exit_code_q  <= '0;
         hi_q         <= '0;
         cnt_q        <= '0;
      end else begin
         rsp_q        <= rsp_d;
         exit_valid_q <= exit_valid_d;
         exit_code_q  <= exit_code_d;
         hi_q         <= hi_d;
         cnt_q        <= cnt_q + 64'd1;
      end
   end

   assign rvalid_o     = rsp_q.rvalid;
   assign rdata_o      = rsp_q.rdata;
   assign exit_valid_o = exit_valid_q;
   assign exit_code_o  = exit_code_q;

   logic unused_in;
   assign unused_in = ^{addr_i[31:12], addr_i[1:0], be_i[3:1]};

endmodule

// File: tb/tb_redmule_mmio_responder.sv
// tb_redmule_mmio_responder: scoreboard bench for the MMIO responder,
// covering both console builds (REDMULE_MMIO_PRINT_FIFO_EN on or off).
module tb_redmule_mmio_responder;
   import redmule_mmio_pkg::*;

   localparam logic [31:0] A_EXIT   = 32'h0000_0000;
   localparam logic [31:0] A_PRINT  = 32'h0000_0004;
   localparam logic [31:0] A_HI     = 32'h0000_0008;
   localparam logic [31:0] A_STATUS = 32'h0000_000C;
   localparam logic [31:0] A_BAD    = 32'h0000_0010;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        exit_valid_o;
   logic [31:0] exit_code_o;
   logic        char_valid_o;
   logic [7:0]  char_o;
   logic        char_ready_i = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   redmule_mmio_responder #(
      .PRINT_FIFO_DEPTH (8),
      .ERR_RDATA        (32'hDEADBEEF)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .gnt_o        (gnt_o),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .exit_valid_o (exit_valid_o),
      .exit_code_o  (exit_code_o),
      .char_valid_o (char_valid_o),
      .char_o       (char_o),
      .char_ready_i (char_ready_i)
   );

   function automatic logic [31:0] sb_pop();
      if (sb.size() == 0) return 'x;
      return sb.pop_front();
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      req_i = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      sb.delete();
   endtask

   // One request from a negedge; returns on the next negedge with the response visible.
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp, output logic g);
      req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
      #1 g = gnt_o;
      if (g) sb.push_back(exp);
      @(negedge clk);
      req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_chk++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++;
         $display("FAIL reset_rsp: rvalid=%b rdata=%h want 0/0", rvalid_o, rdata_o); end
      n_chk++; if (exit_valid_o !== 1'b0 || exit_code_o !== 32'h0) begin n_fail++;
         $display("FAIL reset_exit: valid=%b code=%h want 0/0", exit_valid_o, exit_code_o); end
      n_chk++; if (char_valid_o !== 1'b0 || char_o !== 8'h0) begin n_fail++;
         $display("FAIL reset_char: valid=%b char=%h want 0/0", char_valid_o, char_o); end
      req_i = 1'b1; addr_i = A_STATUS;
      #1;
      n_chk++; if (gnt_o !== 1'b1) begin n_fail++;
         $display("FAIL reset_gnt_hi: gnt=%b want 1", gnt_o); end
      req_i = 1'b0;
      #1;
      n_chk++; if (gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_gnt_lo: gnt=%b want 0", gnt_o); end
   endtask

   task automatic test_exit();
      logic g;
      logic [31:0] e;
      apply_reset();
      issue(A_EXIT, 1'b1, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (g !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL exit_wr0_rsp: gnt=%b rvalid=%b rdata=%h want 1/1/%h", g, rvalid_o, rdata_o, e); end
      n_chk++; if (exit_valid_o !== 1'b1 || exit_code_o !== 32'h0) begin n_fail++;
         $display("FAIL exit_wr0: valid=%b code=%h want 1/0", exit_valid_o, exit_code_o); end
      issue(A_EXIT, 1'b1, 4'hF, 32'h5, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL exit_wr5_rsp: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      n_chk++; if (exit_valid_o !== 1'b1 || exit_code_o !== 32'h5) begin n_fail++;
         $display("FAIL exit_wr5: valid=%b code=%h want 1/5", exit_valid_o, exit_code_o); end
      issue(A_EXIT, 1'b1, 4'h0, 32'hCAFE_0007, 32'h0, g);
      e = sb_pop();
      n_chk++; if (exit_code_o !== 32'hCAFE_0007 || rdata_o !== e) begin n_fail++;
         $display("FAIL exit_be0: code=%h rdata=%h want cafe0007/%h", exit_code_o, rdata_o, e); end
`ifdef REDMULE_MMIO_PRINT_FIFO_EN
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, 32'h3, g);
`else
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, 32'h7, g);
`endif
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL exit_status: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
   endtask

   task automatic test_counter();
      logic g;
      logic [31:0] e;
      apply_reset();
      issue(A_EXIT, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_first: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      issue(A_EXIT, 1'b0, 4'hF, 32'h0, 32'h1, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_second: rdata=%h want %h", rdata_o, e); end
      force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
      #1 release dut.cnt_q;
      issue(A_EXIT, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFE, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_lo_pre: rdata=%h want %h", rdata_o, e); end
      issue(A_HI, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_hi_pre: rdata=%h want %h", rdata_o, e); end
      issue(A_EXIT, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_lo_post: rdata=%h want %h", rdata_o, e); end
      issue(A_HI, 1'b1, 4'hF, 32'h1234, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_hi_wr: rdata=%h want %h", rdata_o, e); end
      issue(A_HI, 1'b0, 4'hF, 32'h0, 32'h1, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL cnt_hi_post: rdata=%h want %h", rdata_o, e); end
   endtask

`ifdef REDMULE_MMIO_PRINT_FIFO_EN
   task automatic test_print();
      logic g;
      logic [31:0] e;
      apply_reset();
      char_ready_i = 1'b0;
      issue(A_PRINT, 1'b1, 4'h1, 32'h48, 32'h0, g);
      e = sb_pop();
      n_chk++; if (g !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL print_h_rsp: gnt=%b rvalid=%b rdata=%h want 1/1/%h", g, rvalid_o, rdata_o, e); end
      issue(A_PRINT, 1'b1, 4'h1, 32'h69, 32'h0, g);
      e = sb_pop();
      issue(A_PRINT, 1'b1, 4'hE, 32'h77, 32'h0, g);
      e = sb_pop();
      n_chk++; if (g !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL print_be0: gnt=%b rdata=%h want 1/%h", g, rdata_o, e); end
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL print_status: rdata=%h want %h", rdata_o, e); end
      issue(A_PRINT, 1'b0, 4'hF, 32'h0, 32'h6, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL print_free: rdata=%h want %h", rdata_o, e); end
      char_ready_i = 1'b1;
      #1;
      n_chk++; if (char_valid_o !== 1'b1 || char_o !== 8'h48) begin n_fail++;
         $display("FAIL print_ch0: valid=%b char=%h want 1/48", char_valid_o, char_o); end
      @(negedge clk); #1;
      n_chk++; if (char_valid_o !== 1'b1 || char_o !== 8'h69) begin n_fail++;
         $display("FAIL print_ch1: valid=%b char=%h want 1/69", char_valid_o, char_o); end
      @(negedge clk); #1;
      n_chk++; if (char_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL print_drained: valid=%b want 0", char_valid_o); end
      char_ready_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full();
      logic g;
      logic [31:0] e;
      apply_reset();
      char_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         issue(A_PRINT, 1'b1, 4'h1, 32'h61 + i, 32'h0, g);
         e = sb_pop();
         n_chk++; if (g !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
            $display("FAIL full_push%0d: gnt=%b rvalid=%b rdata=%h want 1/1/%h", i, g, rvalid_o, rdata_o, e); end
      end
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, 32'h4, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL full_status: rdata=%h want %h", rdata_o, e); end
      issue(A_PRINT, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL full_free: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      req_i = 1'b1; addr_i = A_PRINT; we_i = 1'b1; be_i = 4'h1; wdata_i = 32'h69;
      #1;
      n_chk++; if (gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL full_stall0: gnt=%b want 0", gnt_o); end
      @(negedge clk); #1;
      n_chk++; if (gnt_o !== 1'b0 || rvalid_o !== 1'b0) begin n_fail++;
         $display("FAIL full_stall1: gnt=%b rvalid=%b want 0/0", gnt_o, rvalid_o); end
      char_ready_i = 1'b1;
      #1;
      n_chk++; if (gnt_o !== 1'b0 || char_o !== 8'h61) begin n_fail++;
         $display("FAIL full_pop_same: gnt=%b char=%h want 0/61", gnt_o, char_o); end
      @(negedge clk);
      char_ready_i = 1'b0;
      #1;
      n_chk++; if (gnt_o !== 1'b1) begin n_fail++;
         $display("FAIL full_unstall: gnt=%b want 1", gnt_o); end
      if (gnt_o) sb.push_back(32'h0);
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0; addr_i = '0;
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL full_unstall_rsp: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      char_ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         #1;
         n_chk++; if (char_valid_o !== 1'b1 || char_o !== 8'(8'h62 + j)) begin n_fail++;
            $display("FAIL full_drain%0d: valid=%b char=%h want 1/%h", j, char_valid_o, char_o, 8'(8'h62 + j)); end
         @(negedge clk);
      end
      #1;
      n_chk++; if (char_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL full_empty: valid=%b want 0", char_valid_o); end
      char_ready_i = 1'b0;
      @(negedge clk);
   endtask
`else
   task automatic test_print();
      logic g;
      logic [31:0] e;
      apply_reset();
      char_ready_i = 1'b0;
      req_i = 1'b1; addr_i = A_PRINT; we_i = 1'b1; be_i = 4'h1; wdata_i = 32'h48;
      #1;
      n_chk++; if (char_valid_o !== 1'b1 || char_o !== 8'h48 || gnt_o !== 1'b0) begin n_fail++;
         $display("FAIL comb_stall: valid=%b char=%h gnt=%b want 1/48/0", char_valid_o, char_o, gnt_o); end
      @(negedge clk);
      n_chk++; if (rvalid_o !== 1'b0) begin n_fail++;
         $display("FAIL comb_stall_rsp: rvalid=%b want 0", rvalid_o); end
      char_ready_i = 1'b1;
      #1;
      n_chk++; if (gnt_o !== 1'b1) begin n_fail++;
         $display("FAIL comb_gnt: gnt=%b want 1", gnt_o); end
      if (gnt_o) sb.push_back(32'h0);
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0; addr_i = '0;
      char_ready_i = 1'b0;
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL comb_rsp: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      issue(A_PRINT, 1'b1, 4'hE, 32'h77, 32'h0, g);
      e = sb_pop();
      n_chk++; if (g !== 1'b1 || rdata_o !== e || char_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL comb_be0: gnt=%b rdata=%h valid=%b want 1/%h/0", g, rdata_o, char_valid_o, e); end
      issue(A_PRINT, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL comb_free: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, 32'h6, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL comb_status_nr: rdata=%h want %h", rdata_o, e); end
      char_ready_i = 1'b1;
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, 32'h2, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL comb_status_rdy: rdata=%h want %h", rdata_o, e); end
      char_ready_i = 1'b0;
   endtask

   task automatic test_full();
   endtask
`endif

   task automatic test_back_to_back();
      logic g;
      logic [31:0] e, st;
`ifdef REDMULE_MMIO_PRINT_FIFO_EN
      st = 32'h2;
`else
      st = 32'h6;
`endif
      apply_reset();
      char_ready_i = 1'b0;
      req_i = 1'b1; addr_i = A_BAD; we_i = 1'b0; be_i = 4'hF;
      #1 if (gnt_o) sb.push_back(32'hDEADBEEF);
      @(negedge clk);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL b2b_bad_rd: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      addr_i = A_STATUS;
      #1 if (gnt_o) sb.push_back(st);
      @(negedge clk);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL b2b_status: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      addr_i = A_BAD; we_i = 1'b1; wdata_i = 32'hFFFF_FFFF;
      #1 if (gnt_o) sb.push_back(32'h0);
      @(negedge clk);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL b2b_bad_wr: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      addr_i = 32'h0000_03FC; we_i = 1'b0; wdata_i = '0;
      #1 if (gnt_o) sb.push_back(32'hDEADBEEF);
      @(negedge clk);
      req_i = 1'b0; addr_i = '0; be_i = '0;
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL b2b_bad_hi: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
      @(negedge clk);
      n_chk++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++;
         $display("FAIL b2b_idle: rvalid=%b rdata=%h want 0/0", rvalid_o, rdata_o); end
      n_chk++; if (exit_valid_o !== 1'b0 || exit_code_o !== 32'h0) begin n_fail++;
         $display("FAIL b2b_nochange: valid=%b code=%h want 0/0", exit_valid_o, exit_code_o); end
      issue(A_STATUS, 1'b0, 4'hF, 32'h0, st, g);
      e = sb_pop();
      n_chk++; if (rdata_o !== e) begin n_fail++;
         $display("FAIL b2b_status2: rdata=%h want %h", rdata_o, e); end
   endtask

   task automatic test_reset_mid();
      logic g;
      logic [31:0] e;
      apply_reset();
      char_ready_i = 1'b0;
`ifdef REDMULE_MMIO_PRINT_FIFO_EN
      for (int i = 0; i < 3; i++) begin
         issue(A_PRINT, 1'b1, 4'h1, 32'h30 + i, 32'h0, g);
         e = sb_pop();
      end
      n_chk++; if (char_valid_o !== 1'b1 || char_o !== 8'h30) begin n_fail++;
         $display("FAIL rmid_queued: valid=%b char=%h want 1/30", char_valid_o, char_o); end
`endif
      issue(A_EXIT, 1'b1, 4'hF, 32'h7, 32'h0, g);
      e = sb_pop();
      req_i = 1'b1; addr_i = A_STATUS;
      @(negedge clk);
      req_i = 1'b0; addr_i = '0;
      n_chk++; if (rvalid_o !== 1'b1 || exit_valid_o !== 1'b1) begin n_fail++;
         $display("FAIL rmid_before: rvalid=%b exit=%b want 1/1", rvalid_o, exit_valid_o); end
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      n_chk++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || char_valid_o !== 1'b0) begin n_fail++;
         $display("FAIL rmid_drop: rvalid=%b rdata=%h cvalid=%b want 0/0/0", rvalid_o, rdata_o, char_valid_o); end
      n_chk++; if (exit_valid_o !== 1'b0 || exit_code_o !== 32'h0) begin n_fail++;
         $display("FAIL rmid_exit: valid=%b code=%h want 0/0", exit_valid_o, exit_code_o); end
      issue(A_EXIT, 1'b0, 4'hF, 32'h0, 32'h0, g);
      e = sb_pop();
      n_chk++; if (rvalid_o !== 1'b1 || rdata_o !== e) begin n_fail++;
         $display("FAIL rmid_cnt: rvalid=%b rdata=%h want 1/%h", rvalid_o, rdata_o, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t want finish before 200000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_exit();
      test_counter();
      test_print();
      test_full();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
